// File: rtl/trap_controller.sv
// trap_controller: sequences M-mode trap entry and MRET return.
// Samples the WB slot, synchronises and prioritises interrupt lines,
// arbitrates exception > interrupt > MRET, pulses the CSR file, then
// flushes the pipeline and redirects fetch.
// Ports:
//   clk, rst                 clock, async active-high reset
//   wb_*                     writeback slot (valid, pc, exception, mret, priv)
//   irq_ext/sw/timer         asynchronous level interrupt lines
//   mstatus/mie/mtvec/mepc   current CSR values
//   mem_stall                data-side stall; trap waits in DRAIN
//   exception_commit/mret_commit + exception_*/trap_priv  CSR file update
//   wb_kill                  combinational; suppress WB commit this cycle
//   trap_busy, flush, redirect_valid, redirect_pc  pipeline control
module trap_controller #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_pc,
  input  logic                  wb_exc,
  input  logic [3:0]            wb_exc_code,
  input  logic [DATA_WIDTH-1:0] wb_tval,
  input  logic                  wb_is_mret,
  input  logic [1:0]            wb_priv,
  input  logic                  irq_ext,
  input  logic                  irq_sw,
  input  logic                  irq_timer,
  input  logic [DATA_WIDTH-1:0] mstatus_in,
  input  logic [DATA_WIDTH-1:0] mie_in,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  input  logic                  mem_stall,
  output logic                  exception_commit,
  output logic                  mret_commit,
  output logic [DATA_WIDTH-1:0] exception_pc,
  output logic [DATA_WIDTH-1:0] exception_cause,
  output logic [DATA_WIDTH-1:0] exception_tval,
  output logic [1:0]            trap_priv,
  output logic                  wb_kill,
  output logic                  trap_busy,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_EXT   = 4'd11;
  localparam logic [CODE_W-1:0] CODE_SW    = 4'd3;
  localparam logic [CODE_W-1:0] CODE_TIMER = 4'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [SYNC_STAGES-1:0] sync_ext;
  logic [SYNC_STAGES-1:0] sync_sw;
  logic [SYNC_STAGES-1:0] sync_timer;

  logic              pend_ext;
  logic              pend_sw;
  logic              pend_timer;
  logic              irq_any;
  logic [CODE_W-1:0] irq_code;
  logic              accept_trap;
  logic              accept_ret;

  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] tval_q;
  logic [1:0]            priv_q;
  logic                  is_ret_q;
  logic                  is_irq_q;
  logic [CODE_W-1:0]     code_q;

  logic [DATA_WIDTH-1:0] irq_cause;
  logic [DATA_WIDTH-1:0] tvec_base;
  logic [DATA_WIDTH-1:0] epc_base;

  // Only MIE, the three mie enables and the upper mepc bits matter here.
  logic unused_bits;
  assign unused_bits = ^{mstatus_in, mie_in, mepc_in[1:0]};

  // Interrupt line synchronisers; the MSB flop is the usable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ext   <= '0;
      sync_sw    <= '0;
      sync_timer <= '0;
    end else begin
      sync_ext   <= {sync_ext[SYNC_STAGES-2:0], irq_ext};
      sync_sw    <= {sync_sw[SYNC_STAGES-2:0], irq_sw};
      sync_timer <= {sync_timer[SYNC_STAGES-2:0], irq_timer};
    end
  end

  // Pending interrupts and fixed priority ext > sw > timer.
  always_comb begin
    pend_ext   = sync_ext[SYNC_STAGES-1]   & mie_in[11] & mstatus_in[3];
    pend_sw    = sync_sw[SYNC_STAGES-1]    & mie_in[3]  & mstatus_in[3];
    pend_timer = sync_timer[SYNC_STAGES-1] & mie_in[7]  & mstatus_in[3];
    irq_any    = pend_ext | pend_sw | pend_timer;
    irq_code   = '0;
    if (pend_ext) begin
      irq_code = CODE_EXT;
    end else if (pend_sw) begin
      irq_code = CODE_SW;
    end else if (pend_timer) begin
      irq_code = CODE_TIMER;
    end
    irq_cause                 = DATA_WIDTH'(irq_code);
    irq_cause[DATA_WIDTH-1]   = 1'b1;
    accept_trap = (state == IDLE) & wb_valid & (wb_exc | irq_any);
    accept_ret  = (state == IDLE) & wb_valid & ~wb_exc & ~irq_any & wb_is_mret;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_trap | accept_ret) begin
          next_state = mem_stall ? DRAIN : COMMIT;
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          next_state = COMMIT;
        end
      end
      COMMIT:   next_state = REDIRECT;
      REDIRECT: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Trap record captured on accept; an MRET only updates the kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      priv_q   <= '0;
      is_ret_q <= 1'b0;
      is_irq_q <= 1'b0;
      code_q   <= '0;
    end else if (accept_trap) begin
      cause_q  <= wb_exc ? DATA_WIDTH'(wb_exc_code) : irq_cause;
      pc_q     <= wb_pc;
      tval_q   <= wb_exc ? wb_tval : '0;
      priv_q   <= wb_priv;
      is_ret_q <= 1'b0;
      is_irq_q <= ~wb_exc;
      code_q   <= irq_code;
    end else if (accept_ret) begin
      is_ret_q <= 1'b1;
    end
  end

  // Outputs. mtvec/mepc are read live in REDIRECT so the commit's
  // CSR update is already visible.
  always_comb begin
    tvec_base        = {mtvec_in[DATA_WIDTH-1:2], 2'b00};
    epc_base         = {mepc_in[DATA_WIDTH-1:2], 2'b00};
    exception_commit = 1'b0;
    mret_commit      = 1'b0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    exception_pc     = pc_q;
    exception_cause  = cause_q;
    exception_tval   = tval_q;
    trap_priv        = priv_q;
    trap_busy        = (state != IDLE);
    wb_kill          = (state == IDLE) & wb_valid & (wb_exc | irq_any);
    case (state)
      COMMIT: begin
        exception_commit = ~is_ret_q;
        mret_commit      = is_ret_q;
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (is_ret_q) begin
          redirect_pc = epc_base;
        end else if (is_irq_q && (mtvec_in[1:0] == 2'b01)) begin
          redirect_pc = tvec_base + (DATA_WIDTH'(code_q) << 2);
        end else begin
          redirect_pc = tvec_base;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus a
// randomized loop, each checked against a transaction-level model.
module tb_trap_controller;
  localparam int unsigned DW = 32;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, wb_exc, wb_is_mret;
  logic [DW-1:0] wb_pc, wb_tval;
  logic [3:0]    wb_exc_code;
  logic [1:0]    wb_priv;
  logic          irq_ext, irq_sw, irq_timer;
  logic [DW-1:0] mstatus_in, mie_in, mtvec_in, mepc_in;
  logic          mem_stall;
  logic          exception_commit, mret_commit;
  logic [DW-1:0] exception_pc, exception_cause, exception_tval;
  logic [1:0]    trap_priv;
  logic          wb_kill, trap_busy, flush, redirect_valid;
  logic [DW-1:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  trap_controller #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc(wb_exc),
    .wb_exc_code(wb_exc_code), .wb_tval(wb_tval), .wb_is_mret(wb_is_mret),
    .wb_priv(wb_priv),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .mem_stall(mem_stall),
    .exception_commit(exception_commit), .mret_commit(mret_commit),
    .exception_pc(exception_pc), .exception_cause(exception_cause),
    .exception_tval(exception_tval), .trap_priv(trap_priv),
    .wb_kill(wb_kill), .trap_busy(trap_busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_exc = 1'b0; wb_is_mret = 1'b0; mem_stall = 1'b0;
  endtask

  // Drive irq levels and wait long enough for the synchroniser to settle.
  task automatic settle_irq(input logic e, input logic s, input logic t);
    @(negedge clk);
    idle_inputs();
    irq_ext = e; irq_sw = s; irq_timer = t;
    repeat (SS + 1) @(posedge clk);
  endtask

  // Caller has just driven wb_valid=1 with a fresh irq level at a negedge:
  // wb_kill must stay low for SS cycles, then rise. No accept is let through.
  task automatic irq_walk(input string tag);
    for (int i = 0; i <= int'(SS); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk({tag, "_kill"}, DW'(wb_kill), DW'(i == int'(SS)));
      chk({tag, "_commit"}, DW'(exception_commit), '0);
      chk({tag, "_flush"}, DW'(flush), '0);
    end
    wb_valid = 1'b0;
  endtask

  // One WB transaction through the whole trap/return sequence.
  task automatic txn(input logic exc, input logic [3:0] code, input logic mret,
                     input logic [DW-1:0] pc, input logic [DW-1:0] tval,
                     input logic [1:0] priv, input logic [DW-1:0] mstat,
                     input logic [DW-1:0] mie, input logic [DW-1:0] mtvec,
                     input logic [DW-1:0] mepc, input int nstall, input logic garbage);
    logic pe, ps, pt, any, is_trap, is_ret, is_irq;
    int unsigned icode;
    logic [DW-1:0] e_cause, e_tval, e_redir;
    pe = irq_ext & mie[11] & mstat[3];
    ps = irq_sw & mie[3] & mstat[3];
    pt = irq_timer & mie[7] & mstat[3];
    any = pe | ps | pt;
    icode = pe ? 11 : ps ? 3 : pt ? 7 : 0;
    is_trap = exc | any;
    is_ret  = !is_trap && mret;
    is_irq  = !exc && any;
    e_cause = exc ? DW'(code) : (32'h8000_0000 + DW'(icode));
    e_tval  = exc ? tval : '0;
    if (is_ret) e_redir = mepc & ~32'h3;
    else if (is_irq && mtvec[1:0] == 2'b01) e_redir = (mtvec & ~32'h3) + DW'(icode * 4);
    else e_redir = mtvec & ~32'h3;

    @(negedge clk);
    wb_valid = 1'b1; wb_exc = exc; wb_exc_code = code; wb_is_mret = mret;
    wb_pc = pc; wb_tval = tval; wb_priv = priv;
    mstatus_in = mstat; mie_in = mie; mtvec_in = $urandom; mepc_in = $urandom;
    mem_stall = (nstall > 0);
    #1;
    chk("accept_kill", DW'(wb_kill), DW'(is_trap));
    chk("accept_busy", DW'(trap_busy), '0);
    if (!is_trap && !is_ret) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("none_busy", DW'(trap_busy), '0);
      chk("none_commit", DW'({exception_commit, mret_commit}), '0);
      return;
    end
    for (int k = 1; k <= nstall; k++) begin
      @(negedge clk);
      wb_valid = garbage; wb_exc = garbage; wb_is_mret = garbage;
      mem_stall = (k < nstall);
      #1;
      chk("drain_busy", DW'(trap_busy), 32'd1);
      chk("drain_kill", DW'(wb_kill), '0);
      chk("drain_pulses", DW'({exception_commit, mret_commit, flush}), '0);
    end
    @(negedge clk);
    wb_valid = garbage; wb_exc = garbage; mem_stall = 1'($urandom);
    #1;
    chk("commit_exc", DW'(exception_commit), DW'(is_trap));
    chk("commit_mret", DW'(mret_commit), DW'(is_ret));
    chk("commit_busy", DW'(trap_busy), 32'd1);
    chk("commit_flush", DW'(flush), '0);
    if (is_trap) begin
      chk("cause", exception_cause, e_cause);
      chk("epc", exception_pc, pc);
      chk("tval", exception_tval, e_tval);
      chk("priv", DW'(trap_priv), DW'(priv));
    end
    @(negedge clk);
    idle_inputs();
    mtvec_in = mtvec; mepc_in = mepc;
    #1;
    chk("redir_flush", DW'({flush, redirect_valid}), 32'd3);
    chk("redir_pc", redirect_pc, e_redir);
    chk("redir_pulses", DW'({exception_commit, mret_commit}), '0);
    chk("redir_busy", DW'(trap_busy), 32'd1);
    @(negedge clk);
    #1;
    chk("post_busy", DW'(trap_busy), '0);
    chk("post_flush", DW'({flush, redirect_valid}), '0);
    if (is_trap) chk("post_hold_cause", exception_cause, e_cause);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    irq_ext = 0; irq_sw = 0; irq_timer = 0;
    wb_pc = '0; wb_tval = '0; wb_exc_code = '0; wb_priv = '0;
    mstatus_in = '0; mie_in = '0; mtvec_in = '0; mepc_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", DW'({exception_commit, mret_commit, trap_busy, flush,
                         redirect_valid, wb_kill, trap_priv}), '0);
    chk("rst_cause", exception_cause, '0);
    chk("rst_pc", exception_pc | exception_tval | redirect_pc, '0);
    rst = 1'b0;

    // Illegal instruction
    settle_irq(0, 0, 0);
    txn(1, 4'd2, 0, 32'h100, 32'hDEAD, 2'd3, 32'h8, 32'h0, 32'h8000, 32'h0, 0, 0);

    // Vectored timer interrupt, including synchroniser latency
    @(negedge clk);
    mstatus_in = 32'h8; mie_in = 32'h80; irq_timer = 1; wb_valid = 1; wb_exc = 0;
    irq_walk("sync_timer");
    txn(0, 4'd0, 0, 32'h200, 32'h55, 2'd0, 32'h8, 32'h80, 32'h8001, 32'h0, 0, 0);

    // Priority: exception beats interrupts, ext beats sw
    settle_irq(1, 1, 0);
    txn(1, 4'd11, 0, 32'h300, 32'h1234, 2'd3, 32'h8, 32'h808, 32'h4000, 32'h0, 0, 0);
    txn(0, 4'd11, 0, 32'h304, 32'h1234, 2'd3, 32'h8, 32'h808, 32'h4001, 32'h0, 0, 0);

    // MRET, then MRET pre-empted by a software interrupt
    settle_irq(0, 0, 0);
    txn(0, 4'd0, 1, 32'h400, 32'h0, 2'd3, 32'h8, 32'h888, 32'h4000, 32'h304, 0, 0);
    settle_irq(0, 1, 0);
    txn(0, 4'd0, 1, 32'h404, 32'h0, 2'd3, 32'h8, 32'h8, 32'h4000, 32'h304, 0, 0);

    // Stall with a new exception presented during DRAIN
    settle_irq(0, 0, 0);
    txn(1, 4'd5, 0, 32'h500, 32'hBEEF, 2'd1, 32'h0, 32'h0, 32'h9000, 32'h0, 3, 1);

    // Reset during COMMIT with an enabled external interrupt held high
    settle_irq(1, 0, 0);
    @(negedge clk);
    mstatus_in = 32'h0; mie_in = 32'h800;
    wb_valid = 1; wb_exc = 1; wb_exc_code = 4'd6; wb_pc = 32'h600;
    @(negedge clk);
    idle_inputs();
    mstatus_in = 32'h8;
    #1;
    chk("rmid_commit", DW'(exception_commit), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rmid_outs", DW'({exception_commit, mret_commit, trap_busy, flush,
                          redirect_valid, wb_kill, trap_priv}), '0);
    chk("rmid_fields", exception_cause | exception_pc | exception_tval | redirect_pc, '0);
    @(negedge clk);
    rst = 1'b0;
    wb_valid = 1;
    irq_walk("rmid_sync");

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] mie_r, mtvec_r;
      settle_irq(1'($urandom), 1'($urandom), 1'($urandom));
      mie_r   = ($urandom_range(0, 1) ? 32'h800 : 32'h0) | ($urandom_range(0, 1) ? 32'h8 : 32'h0)
              | ($urandom_range(0, 1) ? 32'h80 : 32'h0);
      mtvec_r = {$urandom, 2'b00};
      mtvec_r[1:0] = 2'($urandom_range(0, 1));
      txn($urandom_range(0, 2) == 0, 4'($urandom), 1'($urandom), $urandom, $urandom,
          2'($urandom), $urandom_range(0, 1) ? 32'h8 : 32'h0, mie_r, mtvec_r, $urandom,
          int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
